// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the decode-stage hazard inputs and the pipeline
// control outputs of the hazard controller.
//   master : pipeline side. Drives the id_* fields, br_taken and mem_wait.
//            Receives the buffer enables/flushes, the forwarding selects and
//            the performance counters.
//   slave  : hazard_ctrl side (directions reversed).
interface hazard_ctrl_if #(
  parameter int RA = 4,
  parameter int CW = 8
);
  logic          id_valid;
  logic [RA-1:0] id_ra;
  logic [RA-1:0] id_rb;
  logic [RA-1:0] id_rc;
  logic          id_regwrite;
  logic          id_memtoreg;
  logic          br_taken;
  logic          mem_wait;

  logic          en_if_id;
  logic          en_id_ex;
  logic          en_ex_mem;
  logic          en_mem_wb;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic          flush_ex_mem;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  modport master (
    output id_valid, id_ra, id_rb, id_rc, id_regwrite, id_memtoreg,
           br_taken, mem_wait,
    input  en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_ra, id_rb, id_rc, id_regwrite, id_memtoreg,
           br_taken, mem_wait,
    output en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Tracks the destination registers of the instructions in EX, MEM and WB in
// shadow slots. From these it derives the ALU forwarding selects, detects
// load-use hazards (one-cycle stall), flushes younger instructions on a
// taken branch and freezes everything while data memory is busy.
// Ports:
//   clk  : pipeline clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : hazard_ctrl_if.slave, carrying the id_* / br_taken / mem_wait
//          inputs and the en_* / flush_* / fwd_* / counter outputs
module hazard_ctrl #(
  parameter int RA = 4,
  parameter int CW = 8
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [RA-1:0] rc;
    logic          regwrite;
    logic          memtoreg;
  } slot_t;

  // WB results are final whether or not they came from a load, so the WB
  // slot does not need the load flag.
  typedef struct packed {
    logic          valid;
    logic [RA-1:0] rc;
    logic          regwrite;
  } wb_slot_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  slot_t         ex_q, ex_d, mem_q, mem_d;
  wb_slot_t      wb_q, wb_d;
  logic [RA-1:0] ex_ra_q, ex_ra_d, ex_rb_q, ex_rb_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic          load_use;
  logic [1:0]    fwd_a_sel, fwd_b_sel;

  // MEM forwards only ALU results (a load's data is not ready yet there);
  // MEM takes priority over WB as it is the younger producer.
  function automatic logic [1:0] fwd_sel(input logic [RA-1:0] src,
                                         input slot_t m, input wb_slot_t w);
    if (m.valid && m.regwrite && !m.memtoreg && m.rc == src) return 2'b01;
    else if (w.valid && w.regwrite && w.rc == src)           return 2'b10;
    else                                                     return 2'b00;
  endfunction

  assign load_use = bus.id_valid && ex_q.valid && ex_q.memtoreg && ex_q.regwrite &&
                    (ex_q.rc == bus.id_ra || ex_q.rc == bus.id_rb);

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (ex_q.valid && !rst) begin
      fwd_a_sel = fwd_sel(ex_ra_q, mem_q, wb_q);
      fwd_b_sel = fwd_sel(ex_rb_q, mem_q, wb_q);
    end
  end

  // Control outputs, highest priority first: reset, freeze, branch, stall.
  always_comb begin
    bus.en_if_id     = 1'b1;
    bus.en_id_ex     = 1'b1;
    bus.en_ex_mem    = 1'b1;
    bus.en_mem_wb    = 1'b1;
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;
    bus.flush_ex_mem = 1'b0;
    if (rst) begin
      bus.flush_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.flush_ex_mem = 1'b1;
    end else if (bus.mem_wait) begin
      bus.en_if_id  = 1'b0;
      bus.en_id_ex  = 1'b0;
      bus.en_ex_mem = 1'b0;
      bus.en_mem_wb = 1'b0;
    end else if (bus.br_taken) begin
      bus.flush_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.flush_ex_mem = 1'b1;
    end else if (load_use) begin
      bus.en_if_id    = 1'b0;
      bus.flush_id_ex = 1'b1;
    end
  end

  assign bus.fwd_a     = fwd_a_sel;
  assign bus.fwd_b     = fwd_b_sel;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  always_comb begin
    ex_d        = ex_q;
    ex_ra_d     = ex_ra_q;
    ex_rb_d     = ex_rb_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.mem_wait) begin
      wb_d           = '{valid: mem_q.valid, rc: mem_q.rc, regwrite: mem_q.regwrite};
      mem_d          = ex_q;
      mem_d.valid    = ex_q.valid && !bus.br_taken;
      ex_d.valid     = bus.id_valid && !load_use && !bus.br_taken;
      ex_d.rc        = bus.id_rc;
      ex_d.regwrite  = bus.id_regwrite;
      ex_d.memtoreg  = bus.id_memtoreg;
      ex_ra_d        = bus.id_ra;
      ex_rb_d        = bus.id_rb;
      // A branch in the same cycle supersedes the stall, so it is not counted.
      if (load_use && !bus.br_taken && stall_cnt_q != CNT_MAX)
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (bus.br_taken && flush_cnt_q != CNT_MAX)
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      ex_ra_q     <= '0;
      ex_rb_q     <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_ra_q     <= ex_ra_d;
      ex_rb_q     <= ex_rb_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int RA = 4;
  localparam int CW = 2;

  localparam logic [3:0] EN_ALL   = 4'b1111;
  localparam logic [3:0] EN_STALL = 4'b0111;
  localparam logic [3:0] EN_FRZ   = 4'b0000;
  localparam logic [2:0] FL_NONE  = 3'b000;
  localparam logic [2:0] FL_ALL   = 3'b111;
  localparam logic [2:0] FL_BUB   = 3'b010;
  // check selectors: control, forwarding, counters
  localparam logic [2:0] S_C = 3'b100, S_F = 3'b010, S_N = 3'b001;
  localparam logic [2:0] S_ALL = 3'b111, S_0 = 3'b000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.RA(RA), .CW(CW)) bus ();
  hazard_ctrl #(.RA(RA), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string         name;
    logic [3:0]    en;
    logic [2:0]    fl;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic [2:0]    sel;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // One pipeline cycle: drive inputs after the edge and push the expected outputs.
  task automatic cyc(input string name, input logic r, input logic v,
                     input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                     input logic rw, input logic mt, input logic br, input logic mw,
                     input logic [3:0] en, input logic [2:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input int sc, input int fc, input logic [2:0] sel);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.id_valid = v;   bus.id_ra = ra;       bus.id_rb = rb;
    bus.id_rc = rc;     bus.id_regwrite = rw; bus.id_memtoreg = mt;
    bus.br_taken = br;  bus.mem_wait = mw;
    e.name = name; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb;
    e.sc = CW'(sc); e.fc = CW'(fc); e.sel = sel;
    sb.push_back(e);
  endtask

  task automatic idle(input string name, input logic [3:0] en, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input int sc, input int fc, input logic [2:0] sel);
    cyc(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, en, fl, fa, fb, sc, fc, sel);
  endtask

  task automatic do_reset();
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_ALL, 0, 0, 0, 0, S_C | S_F);
  endtask

  // Monitor: outputs are valid every cycle; pop one expectation per cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic ok;
    logic [3:0] en_act;
    logic [2:0] fl_act;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      en_act = {bus.en_if_id, bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb};
      fl_act = {bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem};
      if (e.sel != S_0) begin
        ok = 1'b1;
        if (e.sel[2] && (en_act !== e.en || fl_act !== e.fl)) ok = 1'b0;
        if (e.sel[1] && (bus.fwd_a !== e.fa || bus.fwd_b !== e.fb)) ok = 1'b0;
        if (e.sel[0] && (bus.stall_cnt !== e.sc || bus.flush_cnt !== e.fc)) ok = 1'b0;
        checks++;
        if (!ok) errors++;
        $display("%s %s: got en=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d, want en=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d (sel=%b)",
                 ok ? "ok  " : "FAIL", e.name, en_act, fl_act, bus.fwd_a, bus.fwd_b,
                 bus.stall_cnt, bus.flush_cnt, e.en, e.fl, e.fa, e.fb, e.sc, e.fc, e.sel);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.id_valid = 0; bus.id_ra = 0; bus.id_rb = 0; bus.id_rc = 0;
    bus.id_regwrite = 0; bus.id_memtoreg = 0; bus.br_taken = 0; bus.mem_wait = 0;

    // Reset
    cyc("rst_a", 1, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_ALL, 0, 0, 0, 0, S_C | S_F);
    cyc("rst_b", 1, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_ALL, 0, 0, 0, 0, S_ALL);
    idle("post_rst", EN_ALL, FL_NONE, 0, 0, 0, 0, S_ALL);

    // ALU forwarding: back-to-back, one gap, two gaps, MEM-over-WB priority
    cyc("f_add3", 0, 1, 1, 2, 3, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_C | S_F);
    cyc("f_sub",  0, 1, 3, 4, 6, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_C | S_F);
    idle("fwd_mem", EN_ALL, FL_NONE, 2'b01, 2'b00, 0, 0, S_ALL);
    cyc("f_add7", 0, 1, 1, 2, 7, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_F);
    idle("gap1", EN_ALL, FL_NONE, 0, 0, 0, 0, S_0);
    cyc("f_sub7", 0, 1, 7, 0, 8, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_F);
    idle("fwd_wb", EN_ALL, FL_NONE, 2'b10, 2'b00, 0, 0, S_ALL);
    cyc("f_add9", 0, 1, 1, 2, 9, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_0);
    idle("gap2a", EN_ALL, FL_NONE, 0, 0, 0, 0, S_0);
    idle("gap2b", EN_ALL, FL_NONE, 0, 0, 0, 0, S_0);
    cyc("f_sub9", 0, 1, 9, 9, 10, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_0);
    idle("fwd_none", EN_ALL, FL_NONE, 0, 0, 0, 0, S_F);
    cyc("f_add2a", 0, 1, 1, 1, 2, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_0);
    cyc("f_add2b", 0, 1, 3, 3, 2, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_F);
    cyc("f_sub2",  0, 1, 2, 2, 14, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_F);
    idle("fwd_prio", EN_ALL, FL_NONE, 2'b01, 2'b01, 0, 0, S_ALL);

    // Load-use: ld R5 then consumer reading R5 through rb
    do_reset();
    cyc("lu_ld",      0, 1, 1, 0, 5, 1, 1, 0, 0, EN_ALL,   FL_NONE, 0, 0, 0, 0, S_C);
    cyc("lu_stall",   0, 1, 2, 5, 6, 1, 0, 0, 0, EN_STALL, FL_BUB,  0, 0, 0, 0, S_ALL);
    cyc("lu_release", 0, 1, 2, 5, 6, 1, 0, 0, 0, EN_ALL,   FL_NONE, 0, 0, 1, 0, S_ALL);
    idle("lu_fwd", EN_ALL, FL_NONE, 2'b00, 2'b10, 1, 0, S_ALL);

    // Taken branch with EX and MEM occupied; WB producer still forwards
    do_reset();
    cyc("b_add4",  0, 1, 1, 1, 4,  1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_0);
    cyc("b_add11", 0, 1, 1, 1, 11, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_0);
    cyc("b_add12", 0, 1, 4, 1, 12, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_0);
    cyc("br_flush", 0, 1, 4, 12, 13, 1, 0, 1, 0, EN_ALL, FL_ALL, 2'b10, 2'b00, 0, 0, S_ALL);
    cyc("br_after", 0, 1, 12, 11, 13, 1, 0, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 1, S_ALL);
    idle("br_killed", EN_ALL, FL_NONE, 0, 0, 0, 1, S_ALL);

    // mem_wait held over a load-use hazard and a taken branch
    do_reset();
    cyc("w_ld",   0, 1, 0, 0, 5, 1, 1, 0, 0, EN_ALL, FL_NONE, 0, 0, 0, 0, S_C);
    cyc("frz1",   0, 1, 5, 1, 6, 1, 0, 1, 1, EN_FRZ, FL_NONE, 0, 0, 0, 0, S_ALL);
    cyc("frz2",   0, 1, 5, 1, 6, 1, 0, 1, 1, EN_FRZ, FL_NONE, 0, 0, 0, 0, S_ALL);
    cyc("frz3",   0, 1, 5, 1, 6, 1, 0, 1, 1, EN_FRZ, FL_NONE, 0, 0, 0, 0, S_ALL);
    cyc("frz_br", 0, 1, 5, 1, 6, 1, 0, 1, 0, EN_ALL, FL_ALL,  0, 0, 0, 0, S_ALL);
    idle("frz_after", EN_ALL, FL_NONE, 0, 0, 0, 1, S_ALL);

    // Saturation: five load-use stalls on a 2-bit counter
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      cyc("sat_ld",    0, 1, 0, 0, 5, 1, 1, 0, 0, EN_ALL,   FL_NONE, 0, 0, 0, 0, S_0);
      cyc("sat_stall", 0, 1, 2, 5, 6, 1, 0, 0, 0, EN_STALL, FL_BUB,  0, 0,
          (k - 1 > 3) ? 3 : k - 1, 0, S_C | S_N);
      cyc("sat_cnt",   0, 1, 2, 5, 6, 1, 0, 0, 0, EN_ALL,   FL_NONE, 0, 0,
          (k > 3) ? 3 : k, 0, S_C | S_N);
    end
    idle("sat_end", EN_ALL, FL_NONE, 0, 0, 3, 0, S_N);

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It sequences the pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and drives the execute-stage forwarding selects. It keeps a shadow record of in-flight destination registers and uses it to:
- detect load-use hazards and insert one-cycle stalls;
- flush younger instructions on a taken branch;
- freeze the whole pipeline while memory is busy.

It also keeps saturating stall and flush counters for performance debug.

## Interface
- RA, 4, register-number width
- CW, 8, performance counter width
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a valid instruction
- id_ra, id_rb  in  RA  source registers of the decoding instruction
- id_rc  in  RA  destination register of the decoding instruction
- id_regwrite, id_memtoreg  in  1  decoding instruction writes a register / is a load
- br_taken  in  1  branch in MEM stage resolved taken (branchFlag & zeroFlag from EX/MEM)
- mem_wait  in  1  data memory not ready; freeze pipeline
- en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1  buffer enables (PC uses en_if_id)
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  buffer clears
- fwd_a, fwd_b  out  2  ALU operand select: 00 regfile, 01 EX/MEM aluOut, 10 MEM/WB result
- stall_cnt, flush_cnt  out  CW  saturating performance counters

## Operation
- **Shadow slots.** EX, MEM and WB each hold {valid, rc, regwrite, memtoreg}. The EX slot also holds {ra, rb}.
- **Forwarding.** fwd_a is evaluated as follows; fwd_b is identical using EX.rb.
  - fwd_a = 01 if MEM.valid & MEM.regwrite & !MEM.memtoreg & MEM.rc==EX.ra.
  - Otherwise fwd_a = 10 if WB.valid & WB.regwrite & WB.rc==EX.ra.
  - Otherwise fwd_a = 00.
  - MEM has priority over WB. There is no zero-register exception.
  - If EX.valid=0, fwd_a = fwd_b = 00.
- **Load-use detection.** load_use = id_valid & EX.valid & EX.memtoreg & EX.regwrite & (EX.rc==id_ra | EX.rc==id_rb).
- **Output priority** (highest first):
  - mem_wait: all four en = 0, all flushes = 0. br_taken and load_use are ignored; sources hold them until mem_wait falls.
  - br_taken: all en = 1; flush_if_id = flush_id_ex = flush_ex_mem = 1.
  - load_use: en_if_id = 0, flush_id_ex = 1 (bubble); other en = 1.
  - Otherwise: all en = 1, all flushes = 0.
- **Slot update** on each edge without rst:
  - If mem_wait: all slots hold.
  - Otherwise: WB <= MEM.
  - MEM <= EX, or invalid if br_taken.
  - EX <= id fields if id_valid & !load_use & !br_taken; otherwise EX is invalid.
- **Counters.**
  - stall_cnt += 1 on each cycle with load_use & !mem_wait & !br_taken.
  - flush_cnt += 1 on each cycle with br_taken & !mem_wait.
  - Both saturate at 2^CW-1 and do not wrap.

## Timing
- All control outputs are combinational from the slots and current inputs. They are valid in the same cycle, and buffers sample them on the next rising edge.
- **Load-use stall** lasts exactly one cycle.
  - Next cycle the load sits in the MEM slot and the consumer is still in ID; load_use = 0.
  - The cycle after, the consumer reaches EX with the load in WB, giving fwd = 10.
- **Taken branch** costs 3 bubbles; it is a single-cycle event per branch.
- **Reset** (rst high at an edge): all slots invalid and counters = 0.
  - While rst is high, outputs are forced: en all 1, flushes all 1, fwd 00.
  - On the first cycle after rst: flushes 0 and fwd 00.
- **Reset mid-stall or mid-freeze:** rst wins and all pending hazard state is discarded.
- **Simultaneous events:**
  - br_taken + load_use: branch wins; no stall is counted.
  - mem_wait + br_taken: freeze, and the branch is applied on the first cycle mem_wait=0.

## Test plan
- **Reset:** rst 2 cycles -> en=1111, flushes=111, counters 0; next cycle flushes=000, fwd 00.
- **ALU forward:** issue `add R3` then `sub` reading R3 (ra) -> when sub is in EX, fwd_a=01; one instruction gap instead -> fwd_a=10; a gap of 2 -> 00.
- **Load-use:** load to R5 followed by an instruction reading R5 in rb -> one cycle with en_if_id=0 and flush_id_ex=1; next EX cycle fwd_b=10; stall_cnt=1.
- **Taken branch:** assert br_taken for 1 cycle with EX/MEM slots valid -> all three flushes 1, EX and MEM slots invalid next cycle, flush_cnt=1, WB instruction still forwards.
- **mem_wait:** hold 3 cycles during a load-use hazard with br_taken=1 -> all en=0 for 3 cycles, no counter change; then the branch flush takes effect and the stall is discarded.
- **Saturation:** CW=2 with 5 load-use stalls -> stall_cnt stays 3.
